// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared types and helpers for the FIFO read-side stream engine
// Rev 1.0
// ============================================================================
package fifo_pkg;

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} rd_state_t;

   // Beat counter width; a one-beat burst still needs a 1-bit counter.
   function automatic int beat_w(int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// fifo_rd_stream : show-ahead FIFO drain to valid/ready stream, 2-entry skid,
// burst framing. Optional stats ports under FIFO_RD_STREAM_STATS_EN.
// Rev 1.0
// ============================================================================
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             fifo_rd,
   input  logic             flush,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]      beat_total,
   output logic [31:0]      stall_cycles
`endif
);

   localparam int               CNT_W     = beat_w(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   rd_state_t        state, state_nxt;
   logic [WIDTH-1:0] out_reg, skid_reg;
   logic [CNT_W-1:0] beat_cnt;
   logic             take, pop;
   logic             load_out, load_skid, from_skid;

   // Pop depends only on local state, never on m_ready.
   assign pop     = !fifo_empty && !flush && !reset && (state != ST_TWO);
   assign fifo_rd = pop;
   assign m_valid = (state != ST_EMPTY);
   assign take    = m_valid && m_ready;
   assign m_data  = out_reg;
   assign m_last  = m_valid && (beat_cnt == LAST_BEAT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_EMPTY;
         out_reg  <= '0;
         skid_reg <= '0;
         beat_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (load_out)
            out_reg <= from_skid ? skid_reg : fifo_dout;
         if (load_skid)
            skid_reg <= fifo_dout;
         if (flush)
            beat_cnt <= '0;
         else if (take)
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      load_out  = 1'b0;
      load_skid = 1'b0;
      from_skid = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (pop) begin
                  load_out  = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            ST_ONE: begin
               if (pop && take) begin
                  load_out = 1'b1;
               end else if (pop) begin
                  load_skid = 1'b1;
                  state_nxt = ST_TWO;
               end else if (take) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (take) begin
                  load_out  = 1'b1;
                  from_skid = 1'b1;
                  state_nxt = ST_ONE;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         beat_total   <= '0;
         stall_cycles <= '0;
      end else begin
         if (take)
            beat_total <= beat_total + 32'd1;
         if (m_valid && !m_ready)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// tb_fifo_rd_stream : randomized + directed bench against a queue-based model
// Rev 1.0
// ============================================================================
module tb_fifo_rd_stream;

   localparam int WIDTH     = 8;
   localparam int BURST_LEN = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             fifo_empty = 1'b1;
   logic [WIDTH-1:0] fifo_dout = '0;
   logic             fifo_rd;
   logic             flush = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0]      beat_total;
   logic [31:0]      stall_cycles;
`endif

   fifo_rd_stream #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
      .clock       (clock),
      .reset       (reset),
      .fifo_empty  (fifo_empty),
      .fifo_dout   (fifo_dout),
      .fifo_rd     (fifo_rd),
      .flush       (flush),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .beat_total  (beat_total),
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   logic [WIDTH-1:0] fq[$];   // FIFO contents, head at index 0
   logic [WIDTH-1:0] eb[$];   // words popped but not yet accepted downstream
   int               beats = 0;
   bit               after_reset = 1'b0;
   int               exp_total = 0;
   int               exp_stall = 0;
   int               pops_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      fq.push_back(w);
   endtask

   // One clock: drive at negedge, compare before the next posedge, advance the model.
   task automatic cycle(input bit rst_i, input bit fl_i, input bit rdy_i);
      bit exp_valid, exp_rd, take;
      @(negedge clock);
      reset      = rst_i;
      flush      = fl_i;
      m_ready    = rdy_i;
      fifo_empty = (fq.size() == 0);
      fifo_dout  = fifo_empty ? '0 : fq[0];
      #2;
      exp_valid = (eb.size() != 0);
      exp_rd    = !fifo_empty && !fl_i && !rst_i && (eb.size() < 2);
      check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
      check("m_valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("m_data", 32'(m_data), 32'(eb[0]));
         check("m_last", 32'(m_last), 32'((beats % BURST_LEN) == BURST_LEN - 1));
      end else begin
         check("m_last_idle", 32'(m_last), 32'd0);
         if (after_reset)
            check("m_data_reset", 32'(m_data), 32'd0);
      end
`ifdef FIFO_RD_STREAM_STATS_EN
      check("beat_total", beat_total, 32'(exp_total));
      check("stall_cycles", stall_cycles, 32'(exp_stall));
`endif
      take = exp_valid && rdy_i;
      if (rst_i) begin
         exp_total = 0;
         exp_stall = 0;
      end else begin
         if (take) exp_total++;
         if (exp_valid && !rdy_i) exp_stall++;
      end
      after_reset = rst_i;
      if (rst_i || fl_i) begin
         eb.delete();
         beats = 0;
      end else begin
         if (take) begin
            void'(eb.pop_front());
            beats++;
         end
         if (exp_rd) eb.push_back(fq[0]);
      end
      if (fifo_rd) pops_seen++;
      if (fifo_rd && fq.size() != 0) void'(fq.pop_front());
   endtask

   initial begin
      int p0;
      // Reset state
      cycle(1, 0, 0);
      cycle(1, 0, 1);
      check("reset_valid", 32'(m_valid), 32'd0);
      check("reset_data", 32'(m_data), 32'd0);

      // Straight drain of 0x01..0x05 with m_ready held high
      for (int i = 1; i <= 5; i++) push(WIDTH'(i));
      p0 = pops_seen;
      for (int i = 0; i < 8; i++) cycle(0, 0, 1);
      check("drain_pops", 32'(pops_seen - p0), 32'd5);

      // Back-pressure: only two words enter the skid, then release
      for (int i = 0; i < 4; i++) push(WIDTH'(8'hA0 + i));
      p0 = pops_seen;
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
      check("stall_pops", 32'(pops_seen - p0), 32'd2);
      check("stall_data", 32'(m_data), 32'hA0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 1);

      // Burst framing from a clean count
      cycle(0, 1, 1);
      for (int i = 0; i < 10; i++) push(WIDTH'(8'h10 + i));
      for (int i = 0; i < 12; i++) cycle(0, 0, 1);
      check("burst_beats", 32'(beats), 32'd10);

      // Flush while two words are buffered and the count is mid-burst
      for (int i = 0; i < 8; i++) push(WIDTH'(8'h20 + i));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0);
      check("pre_flush_full", 32'(eb.size()), 32'd2);
      cycle(0, 1, 0);
      check("flush_fifo_left", 32'(fq.size()), 32'd6);
      for (int i = 0; i < 9; i++) cycle(0, 0, 1);

      // Reset mid-stream with toggling ready
      for (int i = 0; i < 6; i++) push(WIDTH'(8'h40 + i));
      for (int i = 0; i < 3; i++) cycle(0, 0, 1'($urandom_range(0, 1)));
      cycle(1, 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++) cycle(0, 0, 1);

`ifdef FIFO_RD_STREAM_STATS_EN
      // Stats: 8 beats with 3 stalls, flush keeps them, reset clears them
      cycle(1, 0, 0);
      for (int i = 0; i < 8; i++) push(WIDTH'(8'h60 + i));
      cycle(0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 0, 1);
      check("stats_total", beat_total, 32'd8);
      check("stats_stall", stall_cycles, 32'd3);
      cycle(0, 1, 0);
      cycle(0, 0, 0);
      check("stats_flush_total", beat_total, 32'd8);
      check("stats_flush_stall", stall_cycles, 32'd3);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      check("stats_reset_total", beat_total, 32'd0);
      check("stats_reset_stall", stall_cycles, 32'd0);
`endif

      // Randomized traffic with sporadic flush and reset
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) != 0 && fq.size() < 8) push(WIDTH'($urandom));
         cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 20; i++) cycle(0, 0, 1);
      check("final_drained", 32'(eb.size() + fq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
